// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrated word selector.
// Index arithmetic used by the arbiter search and grant encoding.
package rr_arb_mux_pkg;

   localparam int ARB_N_MAX = 16;

   function automatic int wrap_idx(int base, int off, int n);
      return (base + off) % n;
   endfunction

   function automatic int oh2idx(logic [ARB_N_MAX-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < ARB_N_MAX; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// N-way arbiter: round-robin from a held pointer, or fixed lowest-index.
// Grant is combinational from req and the pointer; pointer moves on en.
module rr_arbiter
   import rr_arb_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int RR    = 1,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic [SEL_W-1:0] last_grant
);

   logic [SEL_W-1:0] r_last;
   logic [N-1:0]     w_gnt;
   logic             w_hit;
   logic [SEL_W-1:0] w_pos;

   always_comb begin
      w_gnt = '0;
      w_hit = 1'b0;
      w_pos = '0;
      for (int k = 0; k < N; k++) begin
         if (RR != 0)
            w_pos = SEL_W'(wrap_idx(int'(r_last), k + 1, N));
         else
            w_pos = SEL_W'(k);
         if (!w_hit && req[w_pos]) begin
            w_gnt[w_pos] = 1'b1;
            w_hit        = 1'b1;
         end
      end
   end

   assign gnt        = w_gnt;
   assign gnt_idx    = SEL_W'(oh2idx(ARB_N_MAX'(w_gnt)));
   assign last_grant = r_last;

   // Reset to N-1 so channel 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last <= SEL_W'(N - 1);
      else if (en && (RR != 0))
         r_last <= gnt_idx;
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrated selector with a single registered output stage.
// One-cycle latency, one word per cycle when the consumer keeps up.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int RR    = 1,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SEL_W-1:0] out_sel
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_sel;

   logic [N-1:0]     w_gnt;
   logic [SEL_W-1:0] w_idx;
   logic [SEL_W-1:0] w_last;
   logic             w_load;
   logic             w_xfer;
   logic [WIDTH-1:0] w_word;

   rr_arbiter #(
      .N     (N),
      .RR    (RR),
      .SEL_W (SEL_W)
   ) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (in_valid),
      .en         (w_xfer),
      .gnt        (w_gnt),
      .gnt_idx    (w_idx),
      .last_grant (w_last)
   );

   // rst_n gates ready so nothing is accepted while reset is held.
   assign w_load   = (!r_valid || out_ready) && rst_n;
   assign in_ready = w_gnt & {N{w_load}};
   assign w_xfer   = |(in_valid & in_ready);

   always_comb begin
      w_word = '0;
      for (int i = 0; i < N; i++) begin
         w_word = w_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_word;
         r_sel   <= w_idx;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;

   logic w_unused;
   assign w_unused = ^w_last;

endmodule
